f_fetch_stage: RTL and testbench

Fetch-stage program counter plus F→D pipeline register for the 5-stage MIPS pipeline with CP0 exceptions. Holds `F_pc`, which addresses instruction memory and feeds `D_NPC`, and registers the `npc` that `D_NPC` computes back into `F_pc` every cycle. Detects fetch address exceptions (AdEL) and carries instruction, PC, delay-slot flag and exception code into D. Honours hazard stalls, CP0 exception requests and `eret` delay-slot squash.

---
 rtl/f_fetch_stage.sv | 93 +++++++++
 tb/tb_f_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_stage.sv
// Fetch-stage PC register and F->D pipeline register with AdEL detection,
// hazard stall, CP0 redirect and eret delay-slot squash.
module f_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        req,
    input  logic        D_eret,
    input  logic        D_is_br,
    input  logic [31:0] F_instr,
    output logic [31:0] F_pc,
    output logic        F_excAdEL,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic        D_bd,
    output logic [4:0]  D_exccode
);

    localparam logic [4:0] ExcNone = 5'd0;
    localparam logic [4:0] ExcAdEL = 5'd4;

    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic        d_bd_q, d_bd_d;
    logic [4:0]  d_exccode_q, d_exccode_d;
    logic        f_adel;

    assign f_adel = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_LO) || (f_pc_q > IM_HI);

    always_comb begin
        f_pc_d = npc;
        if (req) begin
            f_pc_d = EXC_VEC;
        end else if (stall) begin
            f_pc_d = f_pc_q;
        end
    end

    always_comb begin
        d_instr_d   = f_adel ? 32'h0 : F_instr;
        d_pc_d      = f_pc_q;
        d_bd_d      = D_is_br;
        d_exccode_d = f_adel ? ExcAdEL : ExcNone;
        if (req) begin
            d_instr_d   = 32'h0;
            d_pc_d      = EXC_VEC;
            d_bd_d      = 1'b0;
            d_exccode_d = ExcNone;
        end else if (stall) begin
            d_instr_d   = d_instr_q;
            d_pc_d      = d_pc_q;
            d_bd_d      = d_bd_q;
            d_exccode_d = d_exccode_q;
        end else if (D_eret) begin
            // eret has no delay slot: drop the instruction fetched behind it
            d_instr_d   = 32'h0;
            d_pc_d      = f_pc_q;
            d_bd_d      = 1'b0;
            d_exccode_d = ExcNone;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_q      <= RESET_PC;
            d_instr_q   <= 32'h0;
            d_pc_q      <= RESET_PC;
            d_bd_q      <= 1'b0;
            d_exccode_q <= ExcNone;
        end else begin
            f_pc_q      <= f_pc_d;
            d_instr_q   <= d_instr_d;
            d_pc_q      <= d_pc_d;
            d_bd_q      <= d_bd_d;
            d_exccode_q <= d_exccode_d;
        end
    end

    assign F_pc      = f_pc_q;
    assign F_excAdEL = f_adel;
    assign D_instr   = d_instr_q;
    assign D_pc      = d_pc_q;
    assign D_bd      = d_bd_q;
    assign D_exccode = d_exccode_q;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Directed plus randomized check of f_fetch_stage against a behavioural model.
module tb_f_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam logic [31:0] IM_HI    = 32'h0000_6ffc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall, req, D_eret, D_is_br;
    logic [31:0] F_instr;
    logic [31:0] F_pc;
    logic        F_excAdEL;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic        D_bd;
    logic [4:0]  D_exccode;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_dinstr, m_dpc;
    logic        m_dbd;
    logic [4:0]  m_dexc;

    f_fetch_stage #(
        .RESET_PC(RESET_PC),
        .EXC_VEC (EXC_VEC),
        .IM_LO   (IM_LO),
        .IM_HI   (IM_HI)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .npc      (npc),
        .stall    (stall),
        .req      (req),
        .D_eret   (D_eret),
        .D_is_br  (D_is_br),
        .F_instr  (F_instr),
        .F_pc     (F_pc),
        .F_excAdEL(F_excAdEL),
        .D_instr  (D_instr),
        .D_pc     (D_pc),
        .D_bd     (D_bd),
        .D_exccode(D_exccode)
    );

    always #5 clk = ~clk;

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= IM_LO) && (a <= IM_HI);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_dinstr = 0; m_dpc = RESET_PC; m_dbd = 0; m_dexc = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".F_pc"}, F_pc, m_pc);
        chk({tag, ".adel"}, {31'b0, F_excAdEL}, {31'b0, !legal(m_pc)});
        chk({tag, ".D_instr"}, D_instr, m_dinstr);
        chk({tag, ".D_pc"}, D_pc, m_dpc);
        chk({tag, ".D_bd"}, {31'b0, D_bd}, {31'b0, m_dbd});
        chk({tag, ".D_exc"}, {27'b0, D_exccode}, {27'b0, m_dexc});
    endtask

    // One rising edge: the model consumes the inputs as they stand before the edge.
    task automatic cycle(input string tag);
        logic [31:0] n_pc, n_instr, n_dpc;
        logic        n_bd;
        logic [4:0]  n_exc;
        logic        bad;
        bad = !legal(m_pc);
        n_pc = req ? EXC_VEC : (stall ? m_pc : npc);
        if (req) begin
            n_instr = 0; n_dpc = EXC_VEC; n_bd = 0; n_exc = 0;
        end else if (stall) begin
            n_instr = m_dinstr; n_dpc = m_dpc; n_bd = m_dbd; n_exc = m_dexc;
        end else if (D_eret) begin
            n_instr = 0; n_dpc = m_pc; n_bd = 0; n_exc = 0;
        end else begin
            n_instr = bad ? 32'h0 : F_instr;
            n_dpc   = m_pc;
            n_bd    = D_is_br;
            n_exc   = bad ? 5'd4 : 5'd0;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_dinstr = n_instr; m_dpc = n_dpc; m_dbd = n_bd; m_dexc = n_exc;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall = 0; req = 0; D_eret = 0; D_is_br = 0;
        F_instr = $urandom;
    endtask

    initial begin
        logic [31:0] pc_before;
        logic [31:0] d_instr_before;
        int r;
        reset = 1; npc = 0; F_instr = 0;
        idle_inputs();
        #3;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset = 0;

        // Sequential fetch
        for (int i = 0; i < 2; i++) begin
            npc = m_pc + 4; F_instr = $urandom;
            cycle("seq");
        end
        chk("seq_pc_3008", F_pc, 32'h3008);

        // Two-cycle stall at 0x3008
        pc_before = F_pc; d_instr_before = D_instr;
        stall = 1; npc = m_pc + 4;
        for (int i = 0; i < 2; i++) begin
            F_instr = $urandom;
            cycle("stall");
        end
        chk("stall_hold_pc", F_pc, pc_before);
        chk("stall_hold_dinstr", D_instr, d_instr_before);
        stall = 0; F_instr = $urandom;
        cycle("unstall");

        // Misaligned and out-of-range fetch
        npc = 32'h3002; cycle("adel_mis_a");
        chk("adel_mis_flag", {31'b0, F_excAdEL}, 32'd1);
        npc = 32'h7000; F_instr = $urandom; cycle("adel_mis_b");
        chk("adel_mis_dpc", D_pc, 32'h3002);
        chk("adel_mis_exc", {27'b0, D_exccode}, 32'd4);
        npc = 32'h3010; F_instr = $urandom; cycle("adel_hi_b");
        chk("adel_hi_dpc", D_pc, 32'h7000);
        chk("adel_hi_instr", D_instr, 32'h0);

        // Branch delay-slot flag
        D_is_br = 1; npc = 32'h3014; F_instr = $urandom; cycle("br");
        chk("br_dpc", D_pc, 32'h3010);
        chk("br_bd", {31'b0, D_bd}, 32'd1);
        D_is_br = 0; npc = 32'h3018; F_instr = $urandom; cycle("br_next");
        chk("br_next_bd", {31'b0, D_bd}, 32'd0);

        // req overrides stall
        req = 1; stall = 1; F_instr = $urandom; cycle("req_stall");
        chk("req_pc", F_pc, EXC_VEC);
        chk("req_dpc", D_pc, EXC_VEC);
        req = 0; stall = 0; npc = 32'h3020; cycle("to_3020");

        // eret squash, then eret under stall
        D_eret = 1; npc = 32'h3024; F_instr = $urandom; cycle("eret");
        chk("eret_dpc", D_pc, 32'h3020);
        chk("eret_instr", D_instr, 32'h0);
        chk("eret_fpc", F_pc, 32'h3024);
        stall = 1; npc = 32'h3028; F_instr = $urandom; cycle("eret_stall");
        chk("eret_stall_fpc", F_pc, 32'h3024);
        stall = 0; cycle("eret_release");
        chk("eret_release_dpc", D_pc, 32'h3024);
        chk("eret_release_instr", D_instr, 32'h0);
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall   = ($urandom_range(0, 99) < 20);
            req     = ($urandom_range(0, 99) < 5);
            D_eret  = ($urandom_range(0, 99) < 8);
            D_is_br = ($urandom_range(0, 99) < 20);
            F_instr = $urandom;
            r = $urandom_range(0, 99);
            if (r < 70)      npc = m_pc + 4;
            else if (r < 85) npc = IM_LO + 4 * $urandom_range(0, (IM_HI - IM_LO) / 4);
            else if (r < 95) npc = (IM_LO + 4 * $urandom_range(0, 100)) | $urandom_range(1, 3);
            else             npc = $urandom;
            if (!legal(m_pc) && r < 70) npc = 32'h3000;
            if ($urandom_range(0, 99) < 2) begin
                reset = 1;
                #2;
                model_reset();
                check_all("rnd_reset");
                reset = 0;
            end
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
